// File: rtl/mem_bus_controller_if.sv
// Bus bundle for mem_bus_controller: CPU fetch/data request ports plus external memory bus.
// slave = controller view, master = requesters and memory view.
`timescale 1ns/1ps
interface mem_bus_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              err;

    logic [2:0]        ext_cmd;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [BE_W-1:0]   ext_be;
    logic              ext_doe;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ready;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ack,
        output err,
        output ext_cmd, ext_addr, ext_wdata, ext_be, ext_doe,
        input  ext_rdata, ext_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ack,
        input  err,
        input  ext_cmd, ext_addr, ext_wdata, ext_be, ext_doe,
        output ext_rdata, ext_ready
    );
endinterface

// File: rtl/mem_bus_controller.sv
// Arbitrates a fetch port and a data port onto one external memory bus with a timeout watchdog.
// Ports: clk, rst (async active-low), bus (mem_bus_controller_if.slave: req/ack ports + ext bus).
`timescale 1ns/1ps
module mem_bus_controller #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_controller_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_FETCH = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]        state;
    logic              last_d;
    logic              gnt_d;
    logic              gnt_we;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] if_rdata_q;
    logic              if_ack_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              d_ack_q;
    logic              err_q;
    logic [2:0]        ext_cmd_q;
    logic [ADDR_W-1:0] ext_addr_q;
    logic [DATA_W-1:0] ext_wdata_q;
    logic [BE_W-1:0]   ext_be_q;
    logic              ext_doe_q;

    logic              pick_d;
    logic              timed_out;
    logic [DATA_W-1:0] rd_cap;

    // Data wins when alone, or on a tie when fetch had the last grant.
    assign pick_d    = bus.d_req && (!bus.if_req || !last_d);
    assign timed_out = WD_EN && (cnt == CNT_LAST);
    // A completing memory beat delivers its data; an abort delivers zero.
    assign rd_cap    = bus.ext_ready ? bus.ext_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            last_d      <= 1'b0;
            gnt_d       <= 1'b0;
            gnt_we      <= 1'b0;
            cnt         <= '0;
            if_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            ext_cmd_q   <= CMD_IDLE;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
            ext_doe_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        gnt_d  <= pick_d;
                        last_d <= pick_d;
                        cnt    <= '0;
                        state  <= S_BUSY;
                        if (pick_d) begin
                            ext_addr_q  <= bus.d_addr;
                            ext_be_q    <= bus.d_be;
                            ext_wdata_q <= bus.d_wdata;
                            ext_cmd_q   <= bus.d_we ? CMD_WRITE : CMD_READ;
                            ext_doe_q   <= bus.d_we;
                            gnt_we      <= bus.d_we;
                        end else begin
                            ext_addr_q  <= bus.if_addr;
                            ext_be_q    <= '1;
                            ext_wdata_q <= '0;
                            ext_cmd_q   <= CMD_FETCH;
                            ext_doe_q   <= 1'b0;
                            gnt_we      <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    // ext_ready on the timeout edge takes priority.
                    if (bus.ext_ready || timed_out) begin
                        if (gnt_d) begin
                            d_ack_q <= 1'b1;
                            if (!gnt_we)
                                d_rdata_q <= rd_cap;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= rd_cap;
                        end
                        err_q     <= !bus.ext_ready;
                        ext_cmd_q <= CMD_IDLE;
                        ext_doe_q <= 1'b0;
                        ext_be_q  <= '0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    err_q    <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.ext_cmd   = ext_cmd_q;
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign bus.ext_be    = ext_be_q;
    assign bus.ext_doe   = ext_doe_q;
endmodule
